// File: rtl/gpio_bus_master.sv
// gpio_bus_master
//   Bus initiator between the CPU load/store path and the GPIO port.
//   CPU writes become one select cycle. CPU reads become a select cycle
//   plus a sample cycle. An autonomous poll of the input register raises
//   a one-cycle change interrupt with a mask of the bits that changed.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU request (sampled only while idle)
//   cpu_rdata           read data, held until the next CPU read completes
//   cpu_ready, cpu_err  one-cycle completion pulse / out-of-window flag
//   busy                high in every state except IDLE
//   per_addr/wdata/select  GPIO port Address/DataIn/Select
//   per_rdata           GPIO port DataOut (bits 7:0 meaningful)
//   poll_en             enables periodic polling
//   change_irq          one-cycle pulse when a poll sees an input change
//   change_mask         changed bits from the last detected change
module gpio_bus_master #(
    parameter logic [31:0] GPIO_BASE = 32'h1001_0000,
    parameter int unsigned POLL_DIV  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        busy,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic        per_select,
    input  logic [31:0] per_rdata,
    input  logic        poll_en,
    output logic        change_irq,
    output logic [7:0]  change_mask
);

    localparam int CW = $clog2(POLL_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(POLL_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_CAP,
        S_RD_SMP,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            is_poll_q;
    logic            sel_q;
    logic            addr0_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            ready_q;
    logic            err_q;
    logic            irq_q;
    logic [7:0]      mask_q;
    logic [7:0]      last_in_q;
    logic [CW-1:0]   cnt_q;
    logic            pend_q;

    logic            in_win;
    logic            wrap;
    logic            poll_start;
    logic [7:0]      diff_d;
    logic            unused_bits;

    assign in_win     = (cpu_addr[31:3] == GPIO_BASE[31:3]);
    assign wrap       = poll_en && (cnt_q == CNT_MAX);
    // A poll only starts when no CPU request competes for the idle cycle.
    assign poll_start = (state_q == S_IDLE) && !cpu_req && pend_q;
    assign diff_d     = per_rdata[7:0] ^ last_in_q;
    assign unused_bits = ^{per_rdata[31:8], cpu_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            is_poll_q <= 1'b0;
            sel_q     <= 1'b0;
            addr0_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            mask_q    <= '0;
            last_in_q <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;

            // Poll timebase: runs in every state; a wrap while a poll is
            // still pending is dropped, and starting a poll wins over a
            // coincident wrap.
            if (!poll_en) begin
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
                if (poll_start)
                    pend_q <= 1'b0;
                else if (wrap)
                    pend_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        is_poll_q <= 1'b0;
                        if (in_win) begin
                            state_q <= cpu_we ? S_WR : S_RD_CAP;
                            sel_q   <= 1'b1;
                            addr0_q <= cpu_addr[2];
                            wdata_q <= cpu_we ? cpu_wdata : 32'd0;
                        end else begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            if (!cpu_we)
                                rdata_q <= '0;
                        end
                    end else if (pend_q) begin
                        state_q   <= S_RD_CAP;
                        is_poll_q <= 1'b1;
                        sel_q     <= 1'b1;
                        addr0_q   <= 1'b1;
                        wdata_q   <= '0;
                    end
                end
                S_WR: begin
                    state_q <= S_DONE;
                    ready_q <= 1'b1;
                    sel_q   <= 1'b0;
                    addr0_q <= 1'b0;
                    wdata_q <= '0;
                end
                S_RD_CAP: begin
                    state_q <= S_RD_SMP;
                    sel_q   <= 1'b0;
                    addr0_q <= 1'b0;
                    wdata_q <= '0;
                end
                S_RD_SMP: begin
                    if (is_poll_q) begin
                        last_in_q <= per_rdata[7:0];
                        if (diff_d != 8'd0) begin
                            irq_q  <= 1'b1;
                            mask_q <= diff_d;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        rdata_q <= {24'd0, per_rdata[7:0]};
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata   = rdata_q;
    assign cpu_ready   = ready_q;
    assign cpu_err     = err_q;
    assign busy        = (state_q != S_IDLE);
    assign per_addr    = {31'd0, addr0_q};
    assign per_wdata   = wdata_q;
    assign per_select  = sel_q;
    assign change_irq  = irq_q;
    assign change_mask = mask_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master
//   Directed and randomized stimulus for gpio_bus_master with a
//   transaction-level reference model (expected latency per request kind,
//   expected read data, and last polled input value).
module tb_gpio_bus_master;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        busy;
    logic [31:0] per_addr;
    logic [31:0] per_wdata;
    logic        per_select;
    logic [31:0] per_rdata;
    logic        poll_en;
    logic        change_irq;
    logic [7:0]  change_mask;

    gpio_bus_master #(.GPIO_BASE(BASE), .POLL_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_err(cpu_err), .busy(busy),
        .per_addr(per_addr), .per_wdata(per_wdata), .per_select(per_select),
        .per_rdata(per_rdata), .poll_en(poll_en),
        .change_irq(change_irq), .change_mask(change_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Event counters observed mid-cycle.
    int irq_cnt  = 0;
    int bad_irq  = 0;
    int rise_cnt = 0;
    int busy_cnt = 0;
    logic mon_pb = 1'b0;

    always @(negedge clk) begin
        if (change_irq === 1'b1) begin
            irq_cnt++;
            // The pulse belongs to the idle cycle straight after a poll.
            if (busy !== 1'b0 || mon_pb !== 1'b1) bad_irq++;
        end
        if (busy === 1'b1 && mon_pb !== 1'b1) rise_cnt++;
        if (busy === 1'b1) busy_cnt++;
        mon_pb = busy;
    end

    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero_outs(input string p);
        chk({p, "_rdata"}, cpu_rdata, 32'd0);
        chk({p, "_ready"}, {31'd0, cpu_ready}, 32'd0);
        chk({p, "_err"},   {31'd0, cpu_err}, 32'd0);
        chk({p, "_busy"},  {31'd0, busy}, 32'd0);
        chk({p, "_paddr"}, per_addr, 32'd0);
        chk({p, "_pwd"},   per_wdata, 32'd0);
        chk({p, "_psel"},  {31'd0, per_select}, 32'd0);
        chk({p, "_irq"},   {31'd0, change_irq}, 32'd0);
        chk({p, "_mask"},  {24'd0, change_mask}, 32'd0);
    endtask

    // One CPU transaction from an idle cycle; observes cycles N+1..N+4
    // after the accepting edge N.
    task automatic cpu_txn(input string p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [7:0] gin);
        logic inwin;
        int sel_cnt, sel_at, rdy_cnt, rdy_at, exp_lat;
        logic [31:0] sa, sw, rd;
        logic er, busy1, busy4;
        inwin = (addr[31:3] == BASE[31:3]);
        per_rdata = ($urandom() & 32'hFFFF_FF00) | {24'd0, gin};
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom()); cpu_addr = $urandom(); cpu_wdata = $urandom();
        sel_cnt = 0; sel_at = 0; rdy_cnt = 0; rdy_at = 0;
        sa = '0; sw = '0; rd = '0; er = 1'b0; busy1 = 1'b0; busy4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (per_select === 1'b1) begin
                sel_cnt++; sel_at = k; sa = per_addr; sw = per_wdata;
            end
            if (cpu_ready === 1'b1) begin
                rdy_cnt++; rdy_at = k; er = cpu_err; rd = cpu_rdata;
            end
            if (k == 1) busy1 = busy;
            if (k == 4) busy4 = busy;
        end
        exp_lat = !inwin ? 1 : (we ? 2 : 3);
        if (!we) exp_rdata = inwin ? {24'd0, gin} : 32'd0;
        chk({p, "_rdy_cnt"}, rdy_cnt, 1);
        chk({p, "_rdy_lat"}, rdy_at, exp_lat);
        chk({p, "_err"}, {31'd0, er}, {31'd0, !inwin});
        chk({p, "_rdata"}, rd, exp_rdata);
        chk({p, "_sel_cnt"}, sel_cnt, inwin ? 1 : 0);
        chk({p, "_busy1"}, {31'd0, busy1}, 32'd1);
        chk({p, "_busy4"}, {31'd0, busy4}, 32'd0);
        if (inwin) begin
            chk({p, "_sel_at"}, sel_at, 1);
            chk({p, "_paddr"}, sa, {31'd0, addr[2]});
            chk({p, "_pwdata"}, sw, we ? wdata : 32'd0);
        end
    endtask

    initial begin
        int ir0, r0, b0, sel;
        logic [31:0] a;
        logic found, pb;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        per_rdata = '0; poll_en = 1'b0; exp_rdata = '0;
        repeat (3) tick();
        chk_zero_outs("rst0");
        rst = 1'b0;
        tick();

        // Directed requests.
        cpu_txn("wr_a5", 1'b1, BASE, 32'h0000_00A5, 8'h00);
        cpu_txn("rd_in3c", 1'b0, BASE + 32'd4, 32'h0, 8'h3C);
        cpu_txn("rd_oow", 1'b0, 32'h2000_0000, 32'h0, 8'h77);

        // Randomized requests, polling off.
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1:    a = BASE | {29'd0, 1'($urandom()), 2'($urandom())};
                2, 3:    a = BASE | {29'd0, 1'($urandom()), 2'($urandom())};
                4: begin
                    a = $urandom();
                    if (a[31:3] == BASE[31:3]) a = a ^ 32'h8000_0000;
                end
                default: a = ($urandom_range(0, 1) == 1) ? BASE + 32'd8 : BASE - 32'd4;
            endcase
            cpu_txn("rnd", (sel <= 1) ? 1'b1 : 1'($urandom()), a, $urandom(), 8'($urandom()));
        end

        // Periodic polling: first poll against the reset value of last_in.
        per_rdata = $urandom() & 32'hFFFF_FF00;
        poll_en = 1'b1;
        ir0 = irq_cnt;
        repeat (14) tick();
        chk("poll_first_noirq", irq_cnt - ir0, 0);
        r0 = rise_cnt; b0 = busy_cnt;
        repeat (40) tick();
        chk("poll_rate", rise_cnt - r0, 10);
        chk("poll_busy_cycles", busy_cnt - b0, 20);

        per_rdata = ($urandom() & 32'hFFFF_FF00) | 32'h81;
        ir0 = irq_cnt;
        repeat (12) tick();
        chk("poll_chg_irq", irq_cnt - ir0, 1);
        chk("poll_chg_mask", {24'd0, change_mask}, 32'h81);

        per_rdata = ($urandom() & 32'hFFFF_FF00) | 32'h81;
        ir0 = irq_cnt;
        repeat (12) tick();
        chk("poll_same_noirq", irq_cnt - ir0, 0);
        chk("poll_mask_held", {24'd0, change_mask}, 32'h81);

        per_rdata = ($urandom() & 32'hFFFF_FF00) | 32'h7E;
        ir0 = irq_cnt;
        repeat (12) tick();
        chk("poll_chg2_irq", irq_cnt - ir0, 1);
        chk("poll_chg2_mask", {24'd0, change_mask}, 32'hFF);

        // CPU request in the same idle cycle that a poll is pending:
        // find the first idle cycle after a poll, then the next idle cycle
        // is the one immediately before the next poll would start.
        found = 1'b0;
        pb = busy;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (busy === 1'b0 && pb === 1'b1) found = 1'b1;
            pb = busy;
        end
        chk("coll_poll_seen", {31'd0, found}, 32'd1);
        tick();
        ir0 = irq_cnt;
        cpu_txn("coll_rd", 1'b0, BASE + 32'd4, 32'h0, 8'h55);
        tick();
        chk("coll_poll_busy", {31'd0, busy}, 32'd1);
        chk("coll_poll_sel", {31'd0, per_select}, 32'd1);
        chk("coll_poll_addr", per_addr, 32'd1);
        repeat (12) tick();
        chk("coll_irq", irq_cnt - ir0, 1);
        chk("coll_mask", {24'd0, change_mask}, 32'h2B);

        poll_en = 1'b0;
        repeat (4) tick();

        // Asynchronous reset in the middle of a read.
        per_rdata = 32'h0000_0099;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE + 32'd4; cpu_wdata = '0;
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        chk("mid_pre_sel", {31'd0, per_select}, 32'd1);
        rst = 1'b1;
        #1;
        chk_zero_outs("mid_rst");
        exp_rdata = '0;
        tick();
        rst = 1'b0;
        tick();
        cpu_txn("post_rd", 1'b0, BASE + 32'd4, 32'h0, 8'h3C);
        cpu_txn("post_wr", 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 8'h00);

        // last_in must have returned to 0 with reset.
        per_rdata = $urandom() & 32'hFFFF_FF00;
        poll_en = 1'b1;
        ir0 = irq_cnt;
        repeat (20) tick();
        chk("post_poll_noirq", irq_cnt - ir0, 0);
        chk("post_mask", {24'd0, change_mask}, 32'h0);
        poll_en = 1'b0;
        repeat (2) tick();

        chk("irq_timing", bad_irq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
